// File: rtl/cmd_queue_pkg.sv
// rtl/cmd_queue_pkg.sv - shared command types used by the queue, issuer and loader
package cmd_queue_pkg;

    localparam int PROC_COUNT = 4;
    localparam int BUS_W      = 16;

    typedef enum logic [3:0] {
        INSTR_NOP   = 4'h0,
        INSTR_READ  = 4'h1,
        INSTR_WRITE = 4'h2,
        INSTR_ERASE = 4'h3
    } instr_t;

    typedef logic [BUS_W-1:0] addr_t;

    typedef struct packed {
        instr_t                          instr;
        logic [$clog2(PROC_COUNT)-1:0]   proc_id;
        addr_t                           addr;
    } cmd_t;

endpackage

// File: rtl/cmd_queue.sv
// rtl/cmd_queue.sv - first-word-fall-through command FIFO feeding the issuer
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_push,
    input  logic [$bits(cmd_t)-1:0]      i_cmd,
    output logic                         o_full,
    input  logic                         i_rd_queue,
    output logic [$bits(cmd_t)-1:0]      o_cmd,
    output logic                         o_empty,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int W  = $bits(cmd_t);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          pop_ok;
    logic          push_ok;

    assign o_empty     = (count == '0);
    assign o_full      = (count == CW'(DEPTH));
    assign o_count     = count;
    assign o_cmd       = mem[rd_ptr];
    assign o_overflow  = overflow;
    assign o_underflow = underflow;

    // A pop frees the slot this cycle, so a full queue may still accept a push.
    assign pop_ok  = i_rd_queue && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_flush) begin
            mem[wr_ptr] <= i_cmd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (i_rd_queue && o_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_queue.sv
// tb/tb_cmd_queue.sv - self-checking bench for cmd_queue against a queue-based model
module tb_cmd_queue;
    import cmd_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = $bits(cmd_t);
    localparam int CW    = $clog2(DEPTH+1);

    typedef logic [W-1:0] word_t;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_push;
    word_t         i_cmd;
    logic          o_full;
    logic          i_rd_queue;
    word_t         o_cmd;
    logic          o_empty;
    logic          i_flush;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_underflow;

    cmd_queue #(.DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (i_push),
        .i_cmd       (i_cmd),
        .o_full      (o_full),
        .i_rd_queue  (i_rd_queue),
        .o_cmd       (o_cmd),
        .o_empty     (o_empty),
        .i_flush     (i_flush),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int    checks = 0;
    int    errors = 0;
    bit    started = 1'b0;
    word_t mq[$];
    word_t got[$];
    bit    m_ovf = 1'b0;
    bit    m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input int i);
        word_t w;
        w = W'(32'h15A00 + i * 37);
        return w;
    endfunction

    always @(negedge i_clk) begin
        if (started) begin
            chk("count", 32'(o_count), 32'(mq.size()));
            chk("empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("full", 32'(o_full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("underflow", 32'(o_underflow), 32'(m_unf));
            if (mq.size() > 0) begin
                chk("head", 32'(o_cmd), 32'(mq[0]));
            end
        end
    end

    // One clock of stimulus; the model advances from its pre-edge contents.
    task automatic step(input bit push, input word_t cmd, input bit pop, input bit flush);
        int n;
        bit pop_ok;
        bit push_ok;
        i_push     = push;
        i_cmd      = cmd;
        i_rd_queue = pop;
        i_flush    = flush;
        n       = mq.size();
        pop_ok  = pop && (n > 0);
        push_ok = push && ((n < DEPTH) || pop_ok);
        if (pop_ok && !flush) begin
            got.push_back(o_cmd);
        end
        @(posedge i_clk);
        #1;
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && n == 0)    m_unf = 1'b1;
            if (pop_ok)           void'(mq.pop_front());
            if (push_ok)          mq.push_back(cmd);
        end
        i_push     = 1'b0;
        i_rd_queue = 1'b0;
        i_flush    = 1'b0;
    endtask

    localparam word_t A = 22'h0A1111;
    localparam word_t B = 22'h1B2222;
    localparam word_t C = 22'h2C3333;
    localparam word_t X = 22'h2ABCDE;

    initial begin
        i_rstn     = 1'b0;
        i_push     = 1'b0;
        i_cmd      = '0;
        i_rd_queue = 1'b0;
        i_flush    = 1'b0;
        @(posedge i_clk);
        #1;
        started = 1'b1;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_unf", 32'(o_underflow), 32'd0);
        i_rstn = 1'b1;

        step(1'b1, A, 1'b0, 1'b0);
        chk("t1_count1", 32'(o_count), 32'd1);
        chk("t1_headA", 32'(o_cmd), 32'(A));
        chk("t1_empty", 32'(o_empty), 32'd0);
        step(1'b1, B, 1'b0, 1'b0);
        chk("t1_count2", 32'(o_count), 32'd2);
        step(1'b1, C, 1'b0, 1'b0);
        chk("t1_count3", 32'(o_count), 32'd3);

        got.delete();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t2_popA", 32'(got[0]), 32'(A));
            chk("t2_popB", 32'(got[1]), 32'(B));
            chk("t2_popC", 32'(got[2]), 32'(C));
        end
        chk("t2_empty", 32'(o_empty), 32'd1);
        chk("t2_count", 32'(o_count), 32'd0);
        chk("t2_unf", 32'(o_underflow), 32'd0);

        for (int i = 0; i < 8; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        chk("t3_full", 32'(o_full), 32'd1);
        step(1'b1, mk(8), 1'b0, 1'b0);
        chk("t3_ovf", 32'(o_overflow), 32'd1);
        chk("t3_count8", 32'(o_count), 32'd8);
        step(1'b1, mk(9), 1'b1, 1'b0);
        chk("t3_count_pp", 32'(o_count), 32'd8);
        got.delete();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t3_n", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("t3_first", 32'(got[0]), 32'(mk(1)));
            chk("t3_last", 32'(got[7]), 32'(mk(9)));
        end

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, X, 1'b1, 1'b0);
        chk("t4_unf", 32'(o_underflow), 32'd1);
        chk("t4_count", 32'(o_count), 32'd1);
        chk("t4_headX", 32'(o_cmd), 32'(X));
        step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, mk(10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, mk(20 + i), 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_n", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk($sformatf("t5_pop%0d", i), 32'(got[i]), 32'(mk(20 + i)));
        end

        for (int i = 0; i < 9; i++) step(1'b1, mk(30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_pre_count", 32'(o_count), 32'd3);
        chk("t6_pre_ovf", 32'(o_overflow), 32'd1);
        chk("t6_pre_unf", 32'(o_underflow), 32'd1);
        step(1'b1, mk(50), 1'b0, 1'b1);
        chk("t6_count", 32'(o_count), 32'd0);
        chk("t6_empty", 32'(o_empty), 32'd1);
        chk("t6_ovf", 32'(o_overflow), 32'd0);
        chk("t6_unf", 32'(o_underflow), 32'd0);

        step(1'b1, mk(60), 1'b0, 1'b0);
        step(1'b1, mk(61), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, mk(62), 1'b0, 1'b0);
        step(1'b1, mk(63), 1'b0, 1'b0);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("t7_empty", 32'(o_empty), 32'd1);
        chk("t7_count", 32'(o_count), 32'd0);
        chk("t7_full", 32'(o_full), 32'd0);
        chk("t7_ovf", 32'(o_overflow), 32'd0);
        chk("t7_unf", 32'(o_underflow), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        step(1'b1, mk(70), 1'b0, 1'b0);
        chk("t7_after_head", 32'(o_cmd), 32'(mk(70)));
        chk("t7_after_count", 32'(o_count), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
